// File: rtl/serial_pattern_tx.sv
//------------------------------------------------------------------------------
// serial_pattern_tx : shifts a loaded pattern out MSB-first, repeat+1 times,
//                     with a one-cycle done pulse on normal completion.
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             w_o,
  output logic             w_valid_o,
  output logic             done_o
);

  localparam int             BC_W     = $clog2(WIDTH);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_left_q, rep_left_d;
  logic             ready_q, ready_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      rep_left_q <= '0;
      ready_q    <= 1'b1;
      w_q        <= 1'b0;
      w_valid_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_left_q <= rep_left_d;
      ready_q    <= ready_d;
      w_q        <= w_d;
      w_valid_q  <= w_valid_d;
      done_q     <= done_d;
    end
  end

  // Outputs are registered: each cycle computes what the pins show next cycle.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    rep_left_d = rep_left_q;
    ready_d    = 1'b0;
    w_d        = 1'b0;
    w_valid_d  = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ready_q && load_i && !abort_i) begin
          shadow_d   = pattern_i;
          shreg_d    = pattern_i;
          rep_left_d = repeat_i;
          bit_cnt_d  = BIT_LAST;
          ready_d    = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (abort_i) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          w_valid_d = 1'b1;
          w_d       = shreg_q[WIDTH-1];
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - BC_W'(1);
          if (bit_cnt_q == '0) begin
            if (rep_left_q != '0) begin
              // Reload in the same cycle so repetitions run without a gap.
              shreg_d    = shadow_q;
              rep_left_d = rep_left_q - CNT_W'(1);
              bit_cnt_d  = BIT_LAST;
            end else begin
              bit_cnt_d = '0;
              state_d   = DONE;
            end
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o   = ready_q;
  assign w_o       = w_q;
  assign w_valid_o = w_valid_q;
  assign done_o    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
//------------------------------------------------------------------------------
// tb_serial_pattern_tx : directed and randomized checks of serial_pattern_tx
//                        against a per-cycle output timeline model.
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             load  = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] pat   = '0;
  logic [CNT_W-1:0] rpt   = '0;
  logic             ready, w, w_valid, done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .pattern_i (pat),
    .repeat_i  (rpt),
    .abort_i   (abort),
    .ready_o   (ready),
    .w_o       (w),
    .w_valid_o (w_valid),
    .done_o    (done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: an accepted load schedules the exact sequence of output
  // tuples {ready, w_valid, w, done} the pins must show on following cycles.
  logic [3:0] cur = 4'b1000;
  logic [3:0] sched[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched.delete();
      cur = 4'b1000;
    end else begin
      if (cur[3] && load && !abort) begin
        sched.delete();
        sched.push_back(4'b0000);
        for (int r = 0; r <= int'(rpt); r++)
          for (int i = WIDTH - 1; i >= 0; i--)
            sched.push_back({2'b01, pat[i], 1'b0});
        sched.push_back(4'b0001);
      end else if (abort && sched.size() > 0 && sched[0][2]) begin
        sched.delete();
      end
      cur = (sched.size() > 0) ? sched.pop_front() : 4'b1000;
    end
  end

  always @(negedge clk) begin
    if (rst_n) check("cycle", {ready, w_valid, w, done}, cur);
  end

  logic [127:0] stream;
  int nbits, ndone, gaps, first_valid;

  task automatic send(input logic [7:0] p, input logic [3:0] r, input int abort_at, input int noise_at);
    int  cyc;
    bit  finished;
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!ready) check("wait_ready", 0, 1);
    load = 1'b1; pat = p; rpt = r;
    @(negedge clk);
    load = 1'b0; pat = 8'($urandom); rpt = 4'($urandom);
    stream = '0; nbits = 0; ndone = 0; gaps = 0; first_valid = -1; finished = 0;
    for (cyc = 0; cyc < 600; cyc++) begin
      abort = 1'b0; load = 1'b0;
      if (w_valid) begin
        if (first_valid < 0) first_valid = cyc;
        stream = {stream[126:0], w};
        nbits++;
        if (nbits == abort_at) abort = 1'b1;
        if (nbits == noise_at) begin load = 1'b1; pat = 8'hFF; end
      end else if (nbits > 0 && !done && !ready) begin
        gaps++;
      end
      if (done) ndone++;
      if (ready) begin finished = 1; break; end
      @(negedge clk);
    end
    if (!finished) check("send_timeout", 0, 1);
    abort = 1'b0; load = 1'b0;
  endtask

  logic [3:0] hist;
  logic [7:0] det;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_w", w, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'b0000_1111, 4'd0, 0, 0);
    check("single_bits", stream[7:0], 8'b0000_1111);
    check("single_nbits", nbits, 8);
    check("single_done", ndone, 1);
    check("single_latency", first_valid, 1);
    check("single_gaps", gaps, 0);

    send(8'b1000_0001, 4'd2, 0, 0);
    check("repeat_bits", stream[23:0], 24'h818181);
    check("repeat_nbits", nbits, 24);
    check("repeat_done", ndone, 1);
    check("repeat_gaps", gaps, 0);

    send(8'hA5, 4'd0, 4, 0);
    check("abort_bits", stream[3:0], 4'b1010);
    check("abort_nbits", nbits, 4);
    check("abort_done", ndone, 0);
    check("abort_w_valid", w_valid, 0);

    send(8'h00, 4'd0, 0, 3);
    check("ignload_bits", stream[7:0], 8'h00);
    check("ignload_nbits", nbits, 8);
    check("ignload_done", ndone, 1);

    load = 1'b1; abort = 1'b1; pat = 8'hFF;
    @(negedge clk);
    load = 1'b0; abort = 1'b0;
    check("ldab_ready", ready, 1);
    check("ldab_w_valid", w_valid, 0);
    @(negedge clk);
    check("ldab_w_valid2", w_valid, 0);

    // Stand-in for the overlapping 1111/010 Mealy detector fed by valid bits.
    send(8'b0101_1111, 4'd0, 0, 0);
    hist = '0; det = '0;
    for (int i = 0; i < 8; i++) begin
      hist = {hist[2:0], stream[7-i]};
      det[i] = (i >= 3 && hist == 4'b1111) || (i >= 2 && hist[2:0] == 3'b010);
    end
    check("loopback_z", det, 8'b1100_0100);

    send(8'hC3, 4'd15, 0, 0);
    check("maxrep_nbits", nbits, 128);
    check("maxrep_bits", stream, {16{8'hC3}});
    check("maxrep_done", ndone, 1);

    load = 1'b1; pat = 8'hF0; rpt = 4'd1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_valid", w_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", ready, 1);
    check("async_w", w, 0);
    check("async_w_valid", w_valid, 0);
    check("async_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", ready, 1);
    check("post_reset_valid", w_valid, 0);

    for (int c = 0; c < 2000; c++) begin
      load  = ($urandom % 4) == 0;
      pat   = 8'($urandom);
      rpt   = (($urandom % 8) == 0) ? 4'($urandom) : 4'($urandom % 3);
      abort = ($urandom % 40) == 0;
      @(negedge clk);
    end
    load = 1'b0; abort = 1'b0;
    repeat (150) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter that produces the single-bit `w` stream consumed by the team's Mealy sequence detectors. It accepts a WIDTH-bit pattern and a repeat count through a load/ready handshake. It shifts the pattern out MSB-first, one bit per clock, `repeat`+1 times back-to-back, and pulses `done` when finished. It sits between the test/control logic and the detector's `w` input, so a detector can be driven with known bit sequences in system and in simulation.

## Interface
- WIDTH, 8: pattern length in bits (≥2).
- CNT_W, 4: width of the repeat count.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- load  input  1  request to start a transmission; accepted only when `ready`=1.
- pattern  input  WIDTH  bits to transmit, MSB first; sampled on the accepting edge.
- repeat  input  CNT_W  extra repetitions; total transmitted bits = WIDTH*(repeat+1).
- abort  input  1  synchronous cancel of an in-progress transmission.
- ready  output  1  block idle and able to accept `load`.
- w  output  1  serial data bit; forced to 0 when `w_valid`=0.
- w_valid  output  1  `w` carries a pattern bit this cycle.
- done  output  1  one-cycle pulse after the last bit of a completed (non-aborted) transmission.

## Operation
- All outputs are registered. Reset values: ready=1, w=0, w_valid=0, done=0, state=IDLE, counters=0.
- Internal state: shadow register (WIDTH), shift register (WIDTH), bit counter (clog2 WIDTH), repeat counter (CNT_W).
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1, w_valid=0.
  - On load=1 and abort=0: capture pattern into shadow and shift registers, rep_left=repeat, bit_cnt=WIDTH-1, go to SHIFT.
  - load=1 with abort=1 is ignored; abort alone has no effect.
- SHIFT: ready=0, w_valid=1, w=shreg[WIDTH-1]. Each cycle, shift left by one and decrement bit_cnt.
  - If bit_cnt==0 and rep_left!=0: reload shreg from shadow, rep_left-1, bit_cnt=WIDTH-1. There is no idle gap between repetitions.
  - If bit_cnt==0 and rep_left==0: go to DONE.
  - If abort=1 (any bit_cnt): go to IDLE. The next cycle has w_valid=0, w=0, and ready=1. `done` is not pulsed. Abort takes priority over the end-of-pattern transitions.
- DONE: done=1, ready=0, w_valid=0, w=0 for exactly one cycle, then IDLE. abort in DONE is ignored.
- load while ready=0 is ignored; there is no queueing. pattern and repeat are ignored outside the accepting edge.
- Counters never wrap. repeat=2^CNT_W-1 gives 2^CNT_W repetitions.

## Timing
- Load accepted at edge k (ready=1, load=1). First bit (pattern[WIDTH-1]) has w_valid=1 from edge k+1.
- The last bit occupies cycle k+WIDTH*(repeat+1). done=1 in the following cycle. ready=1 again one cycle after done.
- Back-to-back loads: earliest next accept is the edge where ready is first high, i.e. 2 cycles after the last bit.
- Abort sampled at edge m during SHIFT: the bit driven before edge m is the last one, and w_valid=0 from edge m.
- Asynchronous reset mid-transmission immediately forces the reset values. No done pulse is produced and the pattern is discarded. Release is synchronized by the integrator.

## Test plan
- Reset: drive reset=0 mid-SHIFT. Required: w_valid, w, done drop to 0 and ready goes to 1 without a clock edge. After release, the block sits in IDLE.
- Single shot: WIDTH=8, pattern=8'b0000_1111, repeat=0. Required: w=0,0,0,0,1,1,1,1 on 8 consecutive cycles starting 1 cycle after accept, then done=1 for 1 cycle, then ready=1.
- Repeat: pattern=8'b1000_0001, repeat=2. Required: 24 contiguous valid bits (10000001 ×3) with no gap, and exactly one done pulse after bit 24.
- Abort: pattern=8'hA5, abort asserted on the 4th valid bit. Required: bits 1,0,1,0 sent, w_valid=0 next cycle, no done, ready=1.
- Ignored load: pulse load with pattern=8'hFF during an 8'h00 transmission. Required: the stream stays all zeros and completes normally. Also assert load and abort together in IDLE: required ready stays 1 and w_valid stays 0.
- Loopback: feed w into the team's 1111/010 sequence detector, gated by w_valid. Send pattern 8'b0101_1111. Required: the detector output z=1 matches its expected detect cycles.
